// File: rtl/uart_pkg.sv
// Shared types for the 9N1 UART link: word type and transmit-queue FSM states.
package uart_pkg;
  localparam int UART_DATA_W = 9;

  typedef logic [UART_DATA_W-1:0] uart_word_t;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} txq_state_t;
endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO: storage, wrapping pointers and an occupancy count.
// The count alone decides full/empty; a push into a full FIFO succeeds only alongside a pop.
module fifo_sync #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: stale entries are never read while cnt says empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
endmodule

// File: rtl/uart_tx_queue.sv
// Transmit queue in front of UartTX: buffers words and hands them over one frame at a time.
// Optional sticky drop flag (overflow/ovf_clr) is built when UART_TX_QUEUE_OVF_EN is defined.
//
// state     | meaning
// IDLE      | waiting for a queued word and an idle transmitter
// LOAD      | word popped into data; send pulses this cycle
// WAIT_BUSY | waiting for UartTX to drop ready (frame accepted)
// WAIT_DONE | waiting for UartTX to raise ready (frame finished)
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       send,
  output logic [WIDTH-1:0]           data,
  input  logic                       ready
`ifdef UART_TX_QUEUE_OVF_EN
  ,
  output logic                       overflow,
  input  logic                       ovf_clr
`endif
);
  txq_state_t       state;
  txq_state_t       state_nxt;
  logic             pop;
  logic [WIDTH-1:0] head;

  fifo_sync #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (wr_en),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      data  <= '0;
    end else begin
      state <= state_nxt;
      if (pop) data <= head;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && ready) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign send = (state == LOAD);

`ifdef UART_TX_QUEUE_OVF_EN
  logic wr_dropped;
  assign wr_dropped = wr_en && full && !pop;

  // Clear takes priority over a drop in the same cycle.
  always_ff @(posedge clock) begin
    if (reset)           overflow <= 1'b0;
    else if (ovf_clr)    overflow <= 1'b0;
    else if (wr_dropped) overflow <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a behavioural UartTX model driving ready.
// Overflow checks are compiled in when UART_TX_QUEUE_OVF_EN is defined.
module tb_uart_tx_queue;
  import uart_pkg::*;

  localparam int DEPTH = 8;
  localparam int WIDTH = 9;
  localparam int FRAME = 10;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             full;
  logic             empty;
  logic [3:0]       count;
  logic             send;
  logic [WIDTH-1:0] data;
  logic             ready;
`ifdef UART_TX_QUEUE_OVF_EN
  logic             overflow;
  logic             ovf_clr = 1'b0;
`endif

  int tests = 0;
  int failed = 0;

  // UartTX model: 0 idle, 1 accepted but ready still high, 2 busy (ready low)
  int               m_state = 0;
  int               m_cnt = 0;
  logic             m_ready = 1'b1;
  logic             hold_low = 1'b0;
  int               slow_delay = 0;
  logic [WIDTH-1:0] cur_word = '0;
  int               pulses = 0;
  int               data_err = 0;
  logic [WIDTH-1:0] rx_q [$];

  assign ready = m_ready & ~hold_low;

  uart_tx_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .send    (send),
    .data    (data),
    .ready   (ready)
`ifdef UART_TX_QUEUE_OVF_EN
    ,
    .overflow(overflow),
    .ovf_clr (ovf_clr)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (send) pulses <= pulses + 1;
    case (m_state)
      0: if (send) begin
        rx_q.push_back(data);
        cur_word <= data;
        if (slow_delay > 0) begin
          m_state <= 1;
          m_cnt   <= slow_delay;
        end else begin
          m_state <= 2;
          m_ready <= 1'b0;
          m_cnt   <= FRAME;
        end
      end
      1: begin
        if (data !== cur_word) data_err <= data_err + 1;
        if (m_cnt <= 1) begin
          m_state <= 2;
          m_ready <= 1'b0;
          m_cnt   <= FRAME;
        end else m_cnt <= m_cnt - 1;
      end
      default: begin
        if (data !== cur_word) data_err <= data_err + 1;
        if (m_cnt <= 1) begin
          if (!hold_low) begin
            m_state <= 0;
            m_ready <= 1'b1;
          end
        end else m_cnt <= m_cnt - 1;
      end
    endcase
  end

  task automatic wait_drain(input int budget, input string name);
    int stable = 0;
    int n = 0;
    while (stable < 3 && n < budget) begin
      @(negedge clock);
      n++;
      if (empty && m_state == 0 && !send) stable++;
      else stable = 0;
    end
    tests++;
    if (stable < 3) begin
      failed++;
      $display("FAIL %s drain timeout: empty=%0b model_state=%0d after %0d cycles", name, empty, m_state, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      failed++;
      $display("FAIL reset_flags: count=%0d empty=%0b full=%0b want 0 1 0", count, empty, full);
    end
    tests++;
    if (send !== 1'b0 || data !== 9'h000) begin
      failed++;
      $display("FAIL reset_outputs: send=%0b data=%h want 0 000", send, data);
    end
`ifdef UART_TX_QUEUE_OVF_EN
    tests++;
    if (overflow !== 1'b0) begin
      failed++;
      $display("FAIL reset_overflow: got %0b want 0", overflow);
    end
`endif
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single();
    int base = rx_q.size();
    int p0 = pulses;
    int e0 = data_err;
    wr_en = 1'b1; wr_data = 9'h155;
    @(negedge clock);
    wr_en = 1'b0;
    tests++;
    if (empty !== 1'b0 || send !== 1'b0 || count !== 4'd1) begin
      failed++;
      $display("FAIL single_n1: empty=%0b send=%0b count=%0d want 0 0 1", empty, send, count);
    end
    @(negedge clock);
    tests++;
    if (send !== 1'b1 || data !== 9'h155 || empty !== 1'b1) begin
      failed++;
      $display("FAIL single_n2: send=%0b data=%h empty=%0b want 1 155 1", send, data, empty);
    end
    @(negedge clock);
    tests++;
    if (send !== 1'b0) begin
      failed++;
      $display("FAIL single_pulse_width: send=%0b want 0", send);
    end
    wait_drain(200, "single");
    tests++;
    if (rx_q.size() - base !== 1 || rx_q[base] !== 9'h155 || pulses - p0 !== 1) begin
      failed++;
      $display("FAIL single_rx: words=%0d first=%h pulses=%0d want 1 155 1", rx_q.size() - base, rx_q[base], pulses - p0);
    end
    tests++;
    if (data !== 9'h155 || data_err !== e0) begin
      failed++;
      $display("FAIL single_data_hold: data=%h changes=%0d want 155 0", data, data_err - e0);
    end
  endtask

  task automatic test_burst();
    int base = rx_q.size();
    int p0 = pulses;
    int e0 = data_err;
    hold_low = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      wr_en = 1'b1; wr_data = WIDTH'(i);
    end
    @(negedge clock);
    wr_en = 1'b0;
    tests++;
    if (full !== 1'b1 || count !== 4'd8 || send !== 1'b0) begin
      failed++;
      $display("FAIL burst_full: full=%0b count=%0d send=%0b want 1 8 0", full, count, send);
    end
    hold_low = 1'b0;
    wait_drain(1000, "burst");
    tests++;
    if (rx_q.size() - base !== 8 || pulses - p0 !== 8 || data_err !== e0) begin
      failed++;
      $display("FAIL burst_counts: words=%0d pulses=%0d data_changes=%0d want 8 8 0", rx_q.size() - base, pulses - p0, data_err - e0);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rx_q[base + i] !== WIDTH'(i + 1)) begin
        failed++;
        $display("FAIL burst_order[%0d]: got %h want %h", i, rx_q[base + i], WIDTH'(i + 1));
      end
    end
    tests++;
    if (empty !== 1'b1) begin
      failed++;
      $display("FAIL burst_empty: got %0b want 1", empty);
    end
  endtask

  task automatic test_overflow_and_write_pop();
    int base = rx_q.size();
    logic [WIDTH-1:0] exp_w;
    hold_low = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      wr_en = 1'b1; wr_data = WIDTH'(9'h010 + i);
    end
    @(negedge clock);
    wr_data = 9'h1FF;
    @(negedge clock);
    wr_en = 1'b0;
    tests++;
    if (count !== 4'd8 || full !== 1'b1) begin
      failed++;
      $display("FAIL ovf_count: count=%0d full=%0b want 8 1", count, full);
    end
`ifdef UART_TX_QUEUE_OVF_EN
    tests++;
    if (overflow !== 1'b1) begin
      failed++;
      $display("FAIL ovf_set: got %0b want 1", overflow);
    end
    ovf_clr = 1'b1;
    @(negedge clock);
    ovf_clr = 1'b0;
    tests++;
    if (overflow !== 1'b0) begin
      failed++;
      $display("FAIL ovf_clear: got %0b want 0", overflow);
    end
    ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 9'h1FF;
    @(negedge clock);
    ovf_clr = 1'b0; wr_en = 1'b0;
    tests++;
    if (overflow !== 1'b0 || count !== 4'd8) begin
      failed++;
      $display("FAIL ovf_clear_wins: overflow=%0b count=%0d want 0 8", overflow, count);
    end
`endif
    hold_low = 1'b0; wr_en = 1'b1; wr_data = 9'h0AA;
    @(negedge clock);
    wr_en = 1'b0;
    tests++;
    if (count !== 4'd8 || full !== 1'b1 || send !== 1'b1 || data !== 9'h010) begin
      failed++;
      $display("FAIL write_pop_full: count=%0d full=%0b send=%0b data=%h want 8 1 1 010", count, full, send, data);
    end
`ifdef UART_TX_QUEUE_OVF_EN
    tests++;
    if (overflow !== 1'b0) begin
      failed++;
      $display("FAIL write_pop_no_ovf: got %0b want 0", overflow);
    end
`endif
    wait_drain(1500, "overflow");
    tests++;
    if (rx_q.size() - base !== 9) begin
      failed++;
      $display("FAIL ovf_rx_count: got %0d want 9", rx_q.size() - base);
    end
    for (int i = 0; i < 9; i++) begin
      exp_w = (i == 8) ? 9'h0AA : WIDTH'(9'h010 + i);
      tests++;
      if (rx_q[base + i] !== exp_w) begin
        failed++;
        $display("FAIL ovf_rx[%0d]: got %h want %h", i, rx_q[base + i], exp_w);
      end
    end
  endtask

  task automatic test_slow_ready();
    int base = rx_q.size();
    int p0 = pulses;
    slow_delay = 20;
    wr_en = 1'b1; wr_data = 9'h0C1;
    @(negedge clock);
    wr_data = 9'h0C2;
    @(negedge clock);
    wr_en = 1'b0;
    repeat (15) @(negedge clock);
    tests++;
    if (pulses - p0 !== 1 || count !== 4'd1 || send !== 1'b0) begin
      failed++;
      $display("FAIL slow_hold: pulses=%0d count=%0d send=%0b want 1 1 0", pulses - p0, count, send);
    end
    wait_drain(300, "slow");
    slow_delay = 0;
    tests++;
    if (rx_q.size() - base !== 2 || rx_q[base] !== 9'h0C1 || rx_q[base + 1] !== 9'h0C2 || pulses - p0 !== 2) begin
      failed++;
      $display("FAIL slow_rx: words=%0d w0=%h w1=%h pulses=%0d want 2 0c1 0c2 2", rx_q.size() - base, rx_q[base], rx_q[base + 1], pulses - p0);
    end
  endtask

  task automatic test_reset_mid();
    int base = rx_q.size();
    int p0 = pulses;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = WIDTH'(9'h030 + i);
      @(negedge clock);
    end
    wr_en = 1'b0;
    tests++;
    if (count !== 4'd5) begin
      failed++;
      $display("FAIL mid_queued: count=%0d want 5", count);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tests++;
    if (count !== 4'd0 || empty !== 1'b1 || send !== 1'b0) begin
      failed++;
      $display("FAIL mid_reset: count=%0d empty=%0b send=%0b want 0 1 0", count, empty, send);
    end
    wait_drain(300, "reset_mid");
    repeat (5) @(negedge clock);
    tests++;
    if (rx_q.size() - base !== 1 || rx_q[base] !== 9'h030 || pulses - p0 !== 1) begin
      failed++;
      $display("FAIL mid_rx: words=%0d first=%h pulses=%0d want 1 030 1", rx_q.size() - base, rx_q[base], pulses - p0);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_single();
    test_burst();
    test_overflow_and_write_pop();
    test_slow_ready();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
